// File: rtl/cam_pkg.sv
// Shared types for the CAM write-side controller: request opcodes,
// response status codes and controller states.
package cam_pkg;

    typedef enum logic {
        INSERT = 1'b0,
        DELETE = 1'b1
    } cam_op_e;

    typedef enum logic [1:0] {
        OK       = 2'd0,
        DUP      = 2'd1,
        FULL     = 2'd2,
        NOTFOUND = 2'd3
    } cam_status_e;

    typedef enum logic [2:0] {
        FLUSH  = 3'd0,
        IDLE   = 3'd1,
        SEARCH = 3'd2,
        WRITE  = 3'd3,
        RESP   = 3'd4
    } cam_upd_state_e;

endpackage

// File: rtl/cam_free_enc.sv
// Lowest-zero priority encoder over the entry occupancy bitmap.
// any_free is low only when every entry is taken.
module cam_free_enc #(
    parameter int ADDR_WIDTH = 5
) (
    input  logic [(2**ADDR_WIDTH)-1:0] bitmap,
    output logic [ADDR_WIDTH-1:0]      free_idx,
    output logic                       any_free
);
    localparam int DEPTH = 2**ADDR_WIDTH;

    // Scan from the top so the last assignment wins with the lowest free index.
    always_comb begin
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!bitmap[i]) begin
                free_idx = ADDR_WIDTH'(i);
            end
        end
    end

    assign any_free = ~&bitmap;

endmodule

// File: rtl/cam_update_ctrl.sv
// Write-side manager for the CAM: dedups inserts, locates deletes via the
// lookup port, allocates the lowest free entry and auto-flushes after reset.
module cam_update_ctrl
    import cam_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 5,
    parameter int LOOKUP_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_op,
    input  logic [DATA_WIDTH-1:0] req_data,
    input  logic                  flush,
    output logic                  rsp_valid,
    output logic [1:0]            rsp_status,
    output logic [ADDR_WIDTH-1:0] rsp_addr,
    output logic [ADDR_WIDTH:0]   occupancy,
    output logic                  busy,
    output logic                  cam_we,
    output logic [ADDR_WIDTH-1:0] cam_addr,
    output logic [DATA_WIDTH-1:0] cam_data,
    output logic                  cam_valid,
    output logic [DATA_WIDTH-1:0] lookup_data,
    input  logic [ADDR_WIDTH-1:0] lookup_addr,
    input  logic                  lookup_hit
);
    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam int LAT_W = (LOOKUP_LATENCY > 1) ? $clog2(LOOKUP_LATENCY) : 1;
    localparam logic [ADDR_WIDTH:0] OCC_ONE  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0] OCC_FULL = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [LAT_W-1:0]    LAT_ONE  = LAT_W'(1);
    localparam logic [LAT_W-1:0]    LAT_LAST = LAT_W'(LOOKUP_LATENCY - 1);

    cam_upd_state_e        state_reg;
    cam_op_e               op_reg;
    cam_status_e           pend_status_reg;
    cam_status_e           rsp_status_reg;
    logic [DATA_WIDTH-1:0] key_reg;
    logic [DEPTH-1:0]      bitmap_reg;
    logic [ADDR_WIDTH:0]   occ_reg;
    logic [ADDR_WIDTH:0]   flush_cnt_reg;
    logic [LAT_W-1:0]      lat_cnt_reg;
    logic [ADDR_WIDTH-1:0] pend_addr_reg;
    logic [ADDR_WIDTH-1:0] rsp_addr_reg;
    logic                  rsp_valid_reg;
    logic                  busy_reg;
    logic                  cam_we_reg;
    logic [ADDR_WIDTH-1:0] cam_addr_reg;
    logic [DATA_WIDTH-1:0] cam_data_reg;
    logic                  cam_valid_reg;
    logic [DATA_WIDTH-1:0] lookup_data_reg;

    logic [ADDR_WIDTH-1:0] free_idx;
    logic                  any_free;

    cam_free_enc #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_free_enc (
        .bitmap   (bitmap_reg),
        .free_idx (free_idx),
        .any_free (any_free)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= FLUSH;
            op_reg          <= INSERT;
            pend_status_reg <= OK;
            rsp_status_reg  <= OK;
            key_reg         <= '0;
            bitmap_reg      <= '0;
            occ_reg         <= '0;
            flush_cnt_reg   <= '0;
            lat_cnt_reg     <= '0;
            pend_addr_reg   <= '0;
            rsp_addr_reg    <= '0;
            rsp_valid_reg   <= 1'b0;
            busy_reg        <= 1'b0;
            cam_we_reg      <= 1'b0;
            cam_addr_reg    <= '0;
            cam_data_reg    <= '0;
            cam_valid_reg   <= 1'b0;
            lookup_data_reg <= '0;
        end else begin
            cam_we_reg    <= 1'b0;
            rsp_valid_reg <= 1'b0;
            case (state_reg)
                FLUSH: begin
                    // One write per counter value; the extra final step lets the
                    // last invalidate land before requests are accepted.
                    if (flush_cnt_reg == OCC_FULL) begin
                        bitmap_reg <= '0;
                        occ_reg    <= '0;
                        busy_reg   <= 1'b0;
                        state_reg  <= IDLE;
                    end else begin
                        cam_we_reg    <= 1'b1;
                        cam_addr_reg  <= flush_cnt_reg[ADDR_WIDTH-1:0];
                        cam_data_reg  <= '0;
                        cam_valid_reg <= 1'b0;
                        flush_cnt_reg <= flush_cnt_reg + OCC_ONE;
                        busy_reg      <= 1'b1;
                    end
                end
                IDLE: begin
                    if (flush) begin
                        flush_cnt_reg <= '0;
                        busy_reg      <= 1'b1;
                        state_reg     <= FLUSH;
                    end else if (req_valid) begin
                        op_reg          <= cam_op_e'(req_op);
                        key_reg         <= req_data;
                        lookup_data_reg <= req_data;
                        lat_cnt_reg     <= '0;
                        busy_reg        <= 1'b1;
                        state_reg       <= SEARCH;
                    end
                end
                SEARCH: begin
                    if (lat_cnt_reg == LAT_LAST) begin
                        lookup_data_reg <= '0;
                        state_reg       <= WRITE;
                        if (op_reg == INSERT) begin
                            if (lookup_hit) begin
                                pend_status_reg <= DUP;
                                pend_addr_reg   <= lookup_addr;
                            end else if (occ_reg == OCC_FULL || !any_free) begin
                                pend_status_reg <= FULL;
                                pend_addr_reg   <= '0;
                            end else begin
                                cam_we_reg           <= 1'b1;
                                cam_addr_reg         <= free_idx;
                                cam_data_reg         <= key_reg;
                                cam_valid_reg        <= 1'b1;
                                bitmap_reg[free_idx] <= 1'b1;
                                occ_reg              <= occ_reg + OCC_ONE;
                                pend_status_reg      <= OK;
                                pend_addr_reg        <= free_idx;
                            end
                        end else begin
                            if (lookup_hit) begin
                                cam_we_reg              <= 1'b1;
                                cam_addr_reg            <= lookup_addr;
                                cam_data_reg            <= '0;
                                cam_valid_reg           <= 1'b0;
                                bitmap_reg[lookup_addr] <= 1'b0;
                                if (occ_reg != '0) begin
                                    occ_reg <= occ_reg - OCC_ONE;
                                end
                                pend_status_reg <= OK;
                                pend_addr_reg   <= lookup_addr;
                            end else begin
                                pend_status_reg <= NOTFOUND;
                                pend_addr_reg   <= '0;
                            end
                        end
                    end else begin
                        lat_cnt_reg <= lat_cnt_reg + LAT_ONE;
                    end
                end
                WRITE: begin
                    rsp_valid_reg  <= 1'b1;
                    rsp_status_reg <= pend_status_reg;
                    rsp_addr_reg   <= pend_addr_reg;
                    state_reg      <= RESP;
                end
                RESP: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    flush_cnt_reg <= '0;
                    state_reg     <= FLUSH;
                end
            endcase
        end
    end

    assign req_ready   = (state_reg == IDLE) && !flush;
    assign rsp_valid   = rsp_valid_reg;
    assign rsp_status  = rsp_status_reg;
    assign rsp_addr    = rsp_addr_reg;
    assign occupancy   = occ_reg;
    assign busy        = busy_reg;
    assign cam_we      = cam_we_reg;
    assign cam_addr    = cam_addr_reg;
    assign cam_data    = cam_data_reg;
    assign cam_valid   = cam_valid_reg;
    assign lookup_data = lookup_data_reg;

endmodule

// File: tb/tb_cam_update_ctrl.sv
// Directed bench: two controllers (lookup latency 1 and 3, four entries each)
// share one request stream, each backed by a small behavioural CAM.
module tb_cam_update_ctrl;
    import cam_pkg::*;

    localparam int AW    = 2;
    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n;
    logic          req_valid;
    logic          req_op;
    logic          flush;
    logic [DW-1:0] req_data;

    logic [1:0]         req_ready, rsp_valid, busy, cam_we, cam_valid, lookup_hit;
    logic [1:0][1:0]    rsp_status;
    logic [1:0][AW-1:0] rsp_addr, cam_addr, lookup_addr;
    logic [1:0][AW:0]   occupancy;
    logic [1:0][DW-1:0] cam_data, lookup_data;

    int n_checks = 0;
    int n_pass   = 0;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dut
            localparam int LL = (gi == 0) ? 1 : 3;
            bit [DW-1:0] mem [DEPTH];
            bit          vld [DEPTH];
            logic        comb_hit;
            logic [AW-1:0] comb_addr;
            logic [1:0]  hit_sr;
            logic [1:0][AW-1:0] addr_sr;

            always_comb begin
                comb_hit  = 1'b0;
                comb_addr = '0;
                for (int i = DEPTH - 1; i >= 0; i--) begin
                    if (vld[i] && mem[i] == lookup_data[gi]) begin
                        comb_hit  = 1'b1;
                        comb_addr = AW'(i);
                    end
                end
            end

            always_ff @(posedge clk) begin
                hit_sr  <= {hit_sr[0], comb_hit};
                addr_sr <= {addr_sr[0], comb_addr};
                if (cam_we[gi]) begin
                    mem[cam_addr[gi]] <= cam_data[gi];
                    vld[cam_addr[gi]] <= cam_valid[gi];
                end
            end

            assign lookup_hit[gi]  = (LL == 1) ? comb_hit  : hit_sr[1];
            assign lookup_addr[gi] = (LL == 1) ? comb_addr : addr_sr[1];

            cam_update_ctrl #(
                .DATA_WIDTH     (DW),
                .ADDR_WIDTH     (AW),
                .LOOKUP_LATENCY (LL)
            ) u_dut (
                .clk         (clk),
                .reset_n     (reset_n),
                .req_valid   (req_valid),
                .req_ready   (req_ready[gi]),
                .req_op      (req_op),
                .req_data    (req_data),
                .flush       (flush),
                .rsp_valid   (rsp_valid[gi]),
                .rsp_status  (rsp_status[gi]),
                .rsp_addr    (rsp_addr[gi]),
                .occupancy   (occupancy[gi]),
                .busy        (busy[gi]),
                .cam_we      (cam_we[gi]),
                .cam_addr    (cam_addr[gi]),
                .cam_data    (cam_data[gi]),
                .cam_valid   (cam_valid[gi]),
                .lookup_data (lookup_data[gi]),
                .lookup_addr (lookup_addr[gi]),
                .lookup_hit  (lookup_hit[gi])
            );
        end
    endgenerate

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic check_zero_outputs(input string tag);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("%s d%0d ctrl outs", tag, d),
                  {req_ready[d], rsp_valid[d], busy[d], cam_we[d], cam_valid[d],
                   occupancy[d], rsp_status[d], rsp_addr[d], cam_addr[d]}, 64'd0);
            check($sformatf("%s d%0d data outs", tag, d),
                  {cam_data[d], lookup_data[d]}, 64'd0);
        end
    endtask

    // Watches a full flush sequence from the cycle after it was triggered.
    task automatic observe_flush(input string tag);
        int nwr[2], last_we[2], first_rdy[2], nrsp[2];
        for (int d = 0; d < 2; d++) begin
            nwr[d] = 0; last_we[d] = -1; first_rdy[d] = -1; nrsp[d] = 0;
        end
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (cam_we[d]) begin
                    check($sformatf("%s d%0d flush addr", tag, d), 64'(cam_addr[d]), 64'(nwr[d]));
                    check($sformatf("%s d%0d flush data", tag, d), {cam_valid[d], cam_data[d]}, 64'd0);
                    nwr[d]++;
                    last_we[d] = k;
                end
                if (req_ready[d] && first_rdy[d] < 0) first_rdy[d] = k;
                if (rsp_valid[d]) nrsp[d]++;
            end
        end
        for (int d = 0; d < 2; d++) begin
            check($sformatf("%s d%0d flush writes", tag, d), 64'(nwr[d]), 64'(DEPTH));
            check($sformatf("%s d%0d ready after flush", tag, d), 64'(first_rdy[d]), 64'(last_we[d] + 1));
            check($sformatf("%s d%0d no rsp", tag, d), 64'(nrsp[d]), 64'd0);
            check($sformatf("%s d%0d occupancy", tag, d), 64'(occupancy[d]), 64'd0);
        end
        $display("flush %s: writes %0d/%0d ready@%0d/%0d", tag, nwr[0], nwr[1], first_rdy[0], first_rdy[1]);
    endtask

    task automatic send(input logic op, input logic [DW-1:0] key);
        int i = 0;
        while (!(&req_ready) && i < 50) begin
            @(negedge clk);
            i++;
        end
        check("send ready", 64'(&req_ready), 64'd1);
        req_op    = op;
        req_data  = key;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic do_req(input string tag, input logic op, input logic [DW-1:0] key,
                          input logic [1:0] est, input logic [AW-1:0] eaddr,
                          input int ewr, input logic [AW:0] eocc);
        int rsp_k[2], nwr[2];
        logic [1:0] st[2];
        logic [AW-1:0] ad[2];
        logic [34:0] wr[2];
        logic [34:0] exp_wr;
        send(op, key);
        for (int d = 0; d < 2; d++) begin
            rsp_k[d] = -1; nwr[d] = 0; wr[d] = '0; st[d] = '0; ad[d] = '0;
        end
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (rsp_valid[d] && rsp_k[d] < 0) begin
                    rsp_k[d] = k; st[d] = rsp_status[d]; ad[d] = rsp_addr[d];
                end
                if (cam_we[d]) begin
                    nwr[d]++;
                    wr[d] = {cam_valid[d], cam_addr[d], cam_data[d]};
                end
            end
        end
        exp_wr = (op == 1'b0) ? {1'b1, eaddr, key} : {1'b0, eaddr, 32'h0};
        for (int d = 0; d < 2; d++) begin
            check($sformatf("%s d%0d latency", tag, d), 64'(rsp_k[d]), 64'((d == 0) ? 3 : 5));
            check($sformatf("%s d%0d status", tag, d), 64'(st[d]), 64'(est));
            check($sformatf("%s d%0d addr", tag, d), 64'(ad[d]), 64'(eaddr));
            check($sformatf("%s d%0d writes", tag, d), 64'(nwr[d]), 64'(ewr));
            if (ewr != 0) check($sformatf("%s d%0d write word", tag, d), 64'(wr[d]), 64'(exp_wr));
            check($sformatf("%s d%0d occupancy", tag, d), 64'(occupancy[d]), 64'(eocc));
            check($sformatf("%s d%0d status held", tag, d), {rsp_valid[d], rsp_status[d]}, {1'b0, est});
        end
        $display("req %s: op %0d key 0x%08h -> status %0d/%0d addr %0d/%0d lat %0d/%0d occ %0d",
                 tag, op, key, st[0], st[1], ad[0], ad[1], rsp_k[0], rsp_k[1], occupancy[0]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_op    = 1'b0;
        req_data  = '0;
        flush     = 1'b0;
        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        reset_n = 1'b1;
        observe_flush("por");

        do_req("ins_beef", 1'b0, 32'hDEADBEEF, 2'd0, 2'd0, 1, 3'd1);
        do_req("dup_beef", 1'b0, 32'hDEADBEEF, 2'd1, 2'd0, 0, 3'd1);
        do_req("ins_1",    1'b0, 32'h11111111, 2'd0, 2'd1, 1, 3'd2);
        do_req("ins_2",    1'b0, 32'h22222222, 2'd0, 2'd2, 1, 3'd3);
        do_req("ins_3",    1'b0, 32'h33333333, 2'd0, 2'd3, 1, 3'd4);
        do_req("full",     1'b0, 32'h44444444, 2'd2, 2'd0, 0, 3'd4);
        do_req("del_1",    1'b1, 32'h11111111, 2'd0, 2'd1, 1, 3'd3);
        do_req("reuse_1",  1'b0, 32'h55555555, 2'd0, 2'd1, 1, 3'd4);
        do_req("del_miss", 1'b1, 32'h99999999, 2'd3, 2'd0, 0, 3'd4);

        // flush and a request in the same IDLE cycle: flush wins
        flush     = 1'b1;
        req_valid = 1'b1;
        req_op    = 1'b0;
        req_data  = 32'h66666666;
        #1;
        check("flush blocks ready", 64'(req_ready), 64'd0);
        @(posedge clk);
        #1;
        flush     = 1'b0;
        req_valid = 1'b0;
        observe_flush("idle_flush");
        do_req("del_flushed", 1'b1, 32'hDEADBEEF, 2'd3, 2'd0, 0, 3'd0);

        // reset while both controllers sit in SEARCH
        send(1'b0, 32'hCAFEF00D);
        @(negedge clk);
        check("busy in search", 64'(busy), 64'd3);
        reset_n = 1'b0;
        #1;
        check_zero_outputs("mid_reset");
        @(negedge clk);
        reset_n = 1'b1;
        observe_flush("rerun");
        do_req("ins_again", 1'b0, 32'hDEADBEEF, 2'd0, 2'd0, 1, 3'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
